data_memory_port: RTL
=====================

DATA_MEMORY_PORT -- requirements
Module: data_memory_port

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, external memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, data_bus and memory word width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum wait cycles for mem_ack (used only with REQ-026).
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port store_req  input  1  sample data_bus and write it to memory at address.
REQ-007 SHALL have port load_req  input  1  read memory at address and later drive the result onto data_bus.
REQ-008 SHALL have port address  input  ADDR_WIDTH  transfer address, sampled with the accepted request.
REQ-009 SHALL have port bus_grant  input  1  permission to drive data_bus this cycle.
REQ-010 SHALL have port data_bus  inout  DATA_WIDTH  shared 8-bit system data bus.
REQ-011 SHALL have ports mem_req/mem_we output 1, mem_addr output ADDR_WIDTH, mem_wdata output DATA_WIDTH, mem_rdata input DATA_WIDTH, mem_ack input 1, forming the memory-side handshake.
REQ-012 SHALL have outputs busy 1, done 1, error 1, indicating transfer in progress, a one-cycle completion pulse and a one-cycle abort pulse.

Function
REQ-013 SHALL implement states IDLE, MEM_WR, MEM_RD, DRIVE.
REQ-014 In IDLE with store_req=1, SHALL latch address and data_bus in the same cycle and go to MEM_WR.
REQ-015 In IDLE with load_req=1 and store_req=0, SHALL latch address and go to MEM_RD; simultaneous requests give store priority and drop the load.
REQ-016 Requests arriving while not in IDLE SHALL be ignored, not queued.
REQ-017 In MEM_WR, mem_req=1, mem_we=1, mem_addr and mem_wdata equal the latched values; on mem_ack=1, go to IDLE and pulse done next cycle.
REQ-018 In MEM_RD, mem_req=1, mem_we=0; on mem_ack=1, latch mem_rdata and go to DRIVE.
REQ-019 mem_req SHALL stay high until mem_ack is seen; mem_ack outside MEM_WR/MEM_RD SHALL be ignored.
REQ-020 In DRIVE, data_bus SHALL carry the latched read data only in cycles with bus_grant=1; otherwise it SHALL be high-impedance.
REQ-021 DRIVE SHALL hold indefinitely until bus_grant=1; after the first granted cycle, go to IDLE and pulse done.
REQ-022 data_bus SHALL be high-impedance in every state other than DRIVE.
REQ-023 busy SHALL be 1 in all states except IDLE; done and error are never high together.
REQ-024 Minimum latency: store request cycle N, mem_ack at N+1 gives done at N+2; load with ack at N+1 and grant at N+2 gives bus data at N+2 and done at N+3.

Reset
REQ-025 reset=1 SHALL, on the next edge and from any state, force IDLE, mem_req=0, mem_we=0, busy=0, done=0, error=0, mem_addr=0, mem_wdata=0, read latch=0 and data_bus released; an interrupted transfer SHALL NOT pulse done.

Configuration
REQ-026 With macro DATA_MEMORY_PORT_TIMEOUT_EN defined, a counter SHALL count cycles in MEM_WR/MEM_RD; at TIMEOUT_CYCLES without mem_ack, drop mem_req, go to IDLE and pulse error for one cycle (no done).
REQ-027 Without DATA_MEMORY_PORT_TIMEOUT_EN, no counter SHALL exist, error SHALL be tied 0 and MEM_WR/MEM_RD wait indefinitely.

Structure
REQ-028 Package data_memory_port_pkg SHALL hold the state enum typedef and default width/timeout constants.
REQ-029 The timeout counter SHALL be sub-module mem_port_watchdog (clear, enable, expired), instantiated only under the macro.

Verification
REQ-030 Store: data_bus=8'hA5, address=8'h3C, store_req one cycle, mem_ack after 2 waits -> mem_we=1, mem_wdata=A5, mem_addr=3C, done one cycle after ack.
REQ-031 Load: address=8'h10, mem_rdata=8'h5A acked at once, bus_grant low 3 cycles then high -> data_bus Z for 3 cycles, 5A in granted cycle, done next cycle.
REQ-032 store_req and load_req together with address=8'h01 -> only write occurs; load never issued; mem_we=1.
REQ-033 Reset asserted in MEM_RD with mem_req high -> next cycle mem_req=0, busy=0, data_bus Z, no done.
REQ-034 Macro defined, TIMEOUT_CYCLES=16, mem_ack never asserted -> error pulse after 16 cycles, busy=0; without macro busy stays 1.
REQ-035 load_req while busy in MEM_WR -> ignored; exactly one memory transaction observed.

Source files
------------

// File: rtl/data_memory_port_pkg.sv
// -----------------------------------------------------------------------------
// data_memory_port_pkg
// Shared types and default constants for the data_memory_port slice.
//   state_t             : transfer FSM states
//   DMP_ADDR_WIDTH      : default external memory address width
//   DMP_DATA_WIDTH      : default data bus / memory word width
//   DMP_TIMEOUT_CYCLES  : default memory-ack wait limit (watchdog builds only)
// -----------------------------------------------------------------------------
package data_memory_port_pkg;

   localparam int unsigned DMP_ADDR_WIDTH     = 8;
   localparam int unsigned DMP_DATA_WIDTH     = 8;
   localparam int unsigned DMP_TIMEOUT_CYCLES = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MEM_WR = 2'd1,
      MEM_RD = 2'd2,
      DRIVE  = 2'd3
   } state_t;

endpackage

// File: rtl/mem_port_watchdog.sv
// -----------------------------------------------------------------------------
// mem_port_watchdog
// Counts consecutive cycles spent waiting on the memory handshake and flags
// the cycle in which the wait limit is reached.
// Ports:
//   clock   : rising-edge clock
//   reset   : synchronous active-high reset
//   clear   : restart the count (held while no memory access is pending)
//   enable  : a memory access is pending and unacknowledged this cycle
//   expired : this is the TIMEOUT_CYCLES-th pending cycle with no ack
// -----------------------------------------------------------------------------
module mem_port_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + 1'b1;
      end
   end

   // The count holds the number of already-elapsed wait cycles, so the
   // limit is hit while the current (last allowed) cycle is still running.
   assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/data_memory_port.sv
// -----------------------------------------------------------------------------
// data_memory_port
// Bridges a shared tri-state system data bus to a request/ack memory port.
// A store samples data_bus and writes it to memory; a load reads memory and
// drives the word back onto data_bus in the first cycle bus_grant is given.
// One transfer at a time; requests arriving while busy are dropped.
// Optional build macro: DATA_MEMORY_PORT_TIMEOUT_EN adds a watchdog that
// aborts a memory access after TIMEOUT_CYCLES unacknowledged cycles.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   store_req, load_req : transfer requests (store wins if both)
//   address             : transfer address, captured with the request
//   bus_grant           : permission to drive data_bus this cycle
//   data_bus            : shared bidirectional data bus
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack : memory handshake
//   busy                : transfer in progress
//   done                : one-cycle completion pulse
//   error               : one-cycle abort pulse (watchdog builds only)
// -----------------------------------------------------------------------------
module data_memory_port
   import data_memory_port_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = DMP_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH     = DMP_DATA_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = DMP_TIMEOUT_CYCLES
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  store_req,
   input  logic                  load_req,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic                  bus_grant,
   inout  logic [DATA_WIDTH-1:0] data_bus,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  done_q;
   logic                  waiting;
   logic                  timeout_hit;

   assign waiting = (state == MEM_WR) || (state == MEM_RD);

`ifdef DATA_MEMORY_PORT_TIMEOUT_EN
   logic error_q;

   mem_port_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clock  (clock),
      .reset  (reset),
      .clear  (!waiting),
      .enable (waiting && !mem_ack),
      .expired(timeout_hit)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         error_q <= 1'b0;
      end else begin
         error_q <= waiting && timeout_hit;
      end
   end

   assign error = error_q;
`else
   assign timeout_hit = 1'b0;
   assign error       = 1'b0;

   // TIMEOUT_CYCLES stays in the parameter list so both builds share one
   // interface; it has no effect when the watchdog is not built.
   if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (store_req) begin
                  addr_q  <= address;
                  wdata_q <= data_bus;
                  state   <= MEM_WR;
               end else if (load_req) begin
                  addr_q <= address;
                  state  <= MEM_RD;
               end
            end
            MEM_WR: begin
               if (mem_ack) begin
                  done_q <= 1'b1;
                  state  <= IDLE;
               end else if (timeout_hit) begin
                  state <= IDLE;
               end
            end
            MEM_RD: begin
               if (mem_ack) begin
                  rdata_q <= mem_rdata;
                  state   <= DRIVE;
               end else if (timeout_hit) begin
                  state <= IDLE;
               end
            end
            DRIVE: begin
               if (bus_grant) begin
                  done_q <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mem_req   = waiting;
   assign mem_we    = (state == MEM_WR);
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign busy      = (state != IDLE);
   assign done      = done_q;

   assign data_bus = ((state == DRIVE) && bus_grant) ? rdata_q : 'z;

endmodule
